// File: rtl/ex_stage_pkg.sv
// Shared constants, bus layout and helpers for the execute stage.
// The ID->EX struct field order mirrors the packed bus, MSB first.
package ex_stage_pkg;

  localparam int unsigned IdToExWd  = 169;
  localparam int unsigned ExToMemWd = 80;
  localparam int unsigned StallWd   = 6;
  localparam int unsigned DivCycles = 32;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [3:0] ReadenLw  = 4'b1111;
  localparam logic [3:0] ReadenLb  = 4'b0001;
  localparam logic [3:0] ReadenLbu = 4'b0010;
  localparam logic [3:0] ReadenLh  = 4'b0011;
  localparam logic [3:0] ReadenLhu = 4'b0100;
  localparam logic [3:0] ReadenSb  = 4'b0101;
  localparam logic [3:0] ReadenSh  = 4'b0111;

  // Bit positions inside alu_op; add is the MSB.
  localparam int unsigned AluAdd  = 11;
  localparam int unsigned AluSub  = 10;
  localparam int unsigned AluSlt  = 9;
  localparam int unsigned AluSltu = 8;
  localparam int unsigned AluAnd  = 7;
  localparam int unsigned AluNor  = 6;
  localparam int unsigned AluOr   = 5;
  localparam int unsigned AluXor  = 4;
  localparam int unsigned AluSll  = 3;
  localparam int unsigned AluSrl  = 2;
  localparam int unsigned AluSra  = 1;
  localparam int unsigned AluLui  = 0;

  typedef struct packed {
    logic [3:0]  readen;
    logic        mthi;
    logic        mtlo;
    logic        multu;
    logic        mult;
    logic        divu;
    logic        div;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  src1;
    logic [3:0]  src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } id_ex_t;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  function automatic logic is_load(logic [3:0] readen);
    return readen inside {ReadenLw, ReadenLb, ReadenLbu, ReadenLh, ReadenLhu};
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Pipeline-facing buses of the execute stage.
// master = execute stage side, slave = surrounding pipeline side.
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [IdToExWd-1:0]  id_to_ex_bus;
  logic [ExToMemWd-1:0] ex_to_mem_bus;
  logic [37:0]          ex_to_id;
  logic [65:0]          hilo_ex_to_id;
  logic                 ex_is_load;
  logic                 stallreq_for_ex;
  logic                 data_sram_en;
  logic [3:0]           data_sram_wen;
  logic [31:0]          data_sram_addr;
  logic [31:0]          data_sram_wdata;

  modport master (
    input  id_to_ex_bus,
    output ex_to_mem_bus, ex_to_id, hilo_ex_to_id, ex_is_load, stallreq_for_ex,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  modport slave (
    output id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_id, hilo_ex_to_id, ex_is_load, stallreq_for_ex,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/ex_stage_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle on magnitudes,
// signs re-applied in the DONE cycle.
module div_seq
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quo,
  output logic [31:0] rem
);
  localparam int unsigned CntWd = $clog2(DivCycles);

  div_state_e       state_q;
  logic [CntWd-1:0] cnt_q;
  logic [31:0]      quo_q, rem_q, dvs_q;
  logic             neg_quo_q, neg_rem_q;
  logic [32:0]      shifted, trial;

  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: if (start) begin
          quo_q     <= (signed_op && a[31]) ? -a : a;
          dvs_q     <= (signed_op && b[31]) ? -b : b;
          rem_q     <= '0;
          cnt_q     <= '0;
          // A zero divisor keeps the all-ones quotient regardless of signs.
          neg_quo_q <= signed_op && (a[31] ^ b[31]) && (b != '0);
          neg_rem_q <= signed_op && a[31];
          state_q   <= StBusy;
        end
        StBusy: begin
          quo_q <= {quo_q[30:0], ~trial[32]};
          rem_q <= trial[32] ? shifted[31:0] : trial[31:0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntWd'(DivCycles - 1)) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StBusy) || ((state_q == StIdle) && start);
  assign done = (state_q == StDone);
  assign quo  = neg_quo_q ? -quo_q : quo_q;
  assign rem  = neg_rem_q ? -rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: input register, ALU, multiplier, sequential divider,
// data-SRAM request and forwarding/HI-LO buses back to decode.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [StallWd-1:0] stall,
  ex_stage_if.master         bus
);
  id_ex_t      ex_q;
  logic [31:0] src1_v, src2_v, alu_res, rs, rt;
  logic [4:0]  sa;
  logic        div_busy, div_done;
  logic [31:0] div_quo, div_rem;
  logic [63:0] prod_s, prod_u;
  logic        hi_we, lo_we;
  logic [31:0] hi, lo;
  logic [3:0]  wen;
  logic [31:0] wdata;

  // The divider holds its own instruction in place regardless of the stall pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (!div_busy) begin
      if (stall[2] == Stop && stall[3] == NoStop) ex_q <= '0;
      else if (stall[2] == NoStop)                ex_q <= bus.id_to_ex_bus;
    end
  end

  assign rs = ex_q.rs_val;
  assign rt = ex_q.rt_val;

  always_comb begin
    src1_v = ({32{ex_q.src1[0]}} & rs)
           | ({32{ex_q.src1[1]}} & ex_q.pc)
           | ({32{ex_q.src1[2]}} & {27'b0, ex_q.inst[10:6]});
    src2_v = ({32{ex_q.src2[0]}} & rt)
           | ({32{ex_q.src2[1]}} & {{16{ex_q.inst[15]}}, ex_q.inst[15:0]})
           | ({32{ex_q.src2[2]}} & 32'd8)
           | ({32{ex_q.src2[3]}} & {16'b0, ex_q.inst[15:0]});
    sa = src1_v[4:0];
    alu_res = ({32{ex_q.alu_op[AluAdd]}}  & (src1_v + src2_v))
            | ({32{ex_q.alu_op[AluSub]}}  & (src1_v - src2_v))
            | ({32{ex_q.alu_op[AluSlt]}}  & {31'b0, $signed(src1_v) < $signed(src2_v)})
            | ({32{ex_q.alu_op[AluSltu]}} & {31'b0, src1_v < src2_v})
            | ({32{ex_q.alu_op[AluAnd]}}  & (src1_v & src2_v))
            | ({32{ex_q.alu_op[AluNor]}}  & ~(src1_v | src2_v))
            | ({32{ex_q.alu_op[AluOr]}}   & (src1_v | src2_v))
            | ({32{ex_q.alu_op[AluXor]}}  & (src1_v ^ src2_v))
            | ({32{ex_q.alu_op[AluSll]}}  & (src2_v << sa))
            | ({32{ex_q.alu_op[AluSrl]}}  & (src2_v >> sa))
            | ({32{ex_q.alu_op[AluSra]}}  & $unsigned($signed(src2_v) >>> sa))
            | ({32{ex_q.alu_op[AluLui]}}  & {src2_v[15:0], 16'b0});
  end

  div_seq u_div_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (ex_q.div | ex_q.divu),
    .signed_op (ex_q.div),
    .a         (rs),
    .b         (rt),
    .busy      (div_busy),
    .done      (div_done),
    .quo       (div_quo),
    .rem       (div_rem)
  );

  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'b0, rs} * {32'b0, rt};

  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi    = '0;
    lo    = '0;
    if (div_done) begin
      {hi_we, lo_we} = 2'b11;
      {hi, lo}       = {div_rem, div_quo};
    end else if (ex_q.mult) begin
      {hi_we, lo_we} = 2'b11;
      {hi, lo}       = prod_s;
    end else if (ex_q.multu) begin
      {hi_we, lo_we} = 2'b11;
      {hi, lo}       = prod_u;
    end else begin
      if (ex_q.mthi) begin
        hi_we = 1'b1;
        hi    = rs;
      end
      if (ex_q.mtlo) begin
        lo_we = 1'b1;
        lo    = rs;
      end
    end
  end

  always_comb begin
    wen   = '0;
    wdata = rt;
    if (ex_q.ram_en && ex_q.ram_wen != '0) begin
      unique case (ex_q.readen)
        ReadenSb: begin
          wen   = 4'b0001 << alu_res[1:0];
          wdata = {4{rt[7:0]}};
        end
        ReadenSh: begin
          wen   = 4'b0011 << {alu_res[1], 1'b0};
          wdata = {2{rt[15:0]}};
        end
        default: wen = ex_q.ram_wen;
      endcase
    end
  end

  assign bus.data_sram_en    = ex_q.ram_en;
  assign bus.data_sram_wen   = wen;
  assign bus.data_sram_addr  = alu_res;
  assign bus.data_sram_wdata = wdata;

  assign bus.ex_to_mem_bus   = {ex_q.readen, ex_q.pc, ex_q.ram_en, ex_q.ram_wen,
                                ex_q.sel_rf_res, ex_q.rf_we, ex_q.rf_waddr, alu_res};
  assign bus.ex_to_id        = {ex_q.rf_we, ex_q.rf_waddr, alu_res};
  assign bus.hilo_ex_to_id   = {hi_we, lo_we, hi, lo};
  assign bus.ex_is_load      = is_load(ex_q.readen);
  assign bus.stallreq_for_ex = div_busy;

  logic unused_bits;
  assign unused_bits = ^{ex_q.inst[31:16], stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against a behavioural model.
module tb_ex_stage;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bubble = 1'b0;
  logic [5:0] stall;
  int         n_checks = 0;
  int         n_fail = 0;

  localparam logic [5:0] FMthi = 6'b100000, FMtlo = 6'b010000, FMultu = 6'b001000;
  localparam logic [5:0] FMult = 6'b000100, FDivu = 6'b000010, FDiv = 6'b000001;

  always #5 clk = ~clk;

  ex_stage_if bus_if();

  always_comb stall = bubble ? 6'b000100 : {3'b000, {3{bus_if.stallreq_for_ex}}};

  ex_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .bus   (bus_if)
  );

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [168:0] mk(input logic [3:0] readen, input logic [5:0] flags,
      input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic ram_en, input logic [3:0] ram_wen,
      input logic rf_we, input logic [4:0] waddr, input logic sel,
      input logic [31:0] rs, input logic [31:0] rt);
    return {readen, flags, pc, inst, op, s1, s2, ram_en, ram_wen, rf_we, waddr, sel, rs, rt};
  endfunction

  // k: 0=add 1=sub 2=slt 3=sltu 4=and 5=nor 6=or 7=xor 8=sll 9=srl 10=sra 11=lui 12=none
  function automatic logic [31:0] ref_alu(input int k, input logic [31:0] a,
                                          input logic [31:0] b);
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << a[4:0];
      9:  return b >> a[4:0];
      10: return $unsigned($signed(b) >>> a[4:0]);
      11: return {b[15:0], 16'h0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic issue(input logic [168:0] b);
    @(negedge clk);
    bus_if.id_to_ex_bus = b;
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    logic [63:0] exp;
    exp = ref_div(sgn, a, b);
    issue(mk(4'd0, sgn ? FDiv : FDivu, 32'h100, 32'h0, 12'h0, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b));
    bus_if.id_to_ex_bus = '0;
    cyc = 0;
    while (bus_if.stallreq_for_ex && cyc < 100) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    check("div_stall_cycles", 80'(cyc), 80'd33);
    check("div_hilo", 80'(bus_if.hilo_ex_to_id), 80'({2'b11, exp}));
    @(posedge clk);
    #1;
    check("div_we_drop", 80'(bus_if.hilo_ex_to_id[65:64]), 80'd0);
  endtask

  initial begin
    logic [31:0] rs, rt, pc, inst, res, a1, a2, addr;
    logic [63:0] p;
    logic [4:0]  wa;
    int          k, j1, j2, kind;

    bus_if.id_to_ex_bus = '0;
    #12;
    check("rst_ex_to_mem", 80'(bus_if.ex_to_mem_bus), 80'd0);
    check("rst_hilo", 80'(bus_if.hilo_ex_to_id), 80'd0);
    check("rst_stallreq", 80'(bus_if.stallreq_for_ex), 80'd0);
    check("rst_sram_en", 80'(bus_if.data_sram_en), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addiu rs=5, imm=0xFFFF, rt=9
    inst = {6'b001001, 5'd3, 5'd9, 16'hFFFF};
    issue(mk(4'd0, 6'd0, 32'h40, inst, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0,
             1'b1, 5'd9, 1'b0, 32'd5, 32'd0));
    check("addiu_ex_to_id", 80'(bus_if.ex_to_id), 80'({1'b1, 5'd9, 32'd4}));
    check("addiu_ex_to_mem", bus_if.ex_to_mem_bus,
          {4'd0, 32'h40, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'd4});

    // bubble: EX stopped, MEM running
    bubble = 1'b1;
    issue(mk(4'd0, 6'd0, 32'h44, inst, 12'h800, 3'b001, 4'b0010, 1'b0, 4'h0,
             1'b1, 5'd9, 1'b0, 32'd7, 32'd0));
    check("bubble_ex_to_mem", bus_if.ex_to_mem_bus, 80'd0);
    bubble = 1'b0;

    // random ALU
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 12));
      j1 = int'($urandom_range(0, 2));
      j2 = int'($urandom_range(0, 3));
      rs = $urandom; rt = $urandom; pc = $urandom; inst = $urandom; wa = 5'($urandom);
      a1 = (j1 == 0) ? rs : (j1 == 1) ? pc : {27'b0, inst[10:6]};
      a2 = (j2 == 0) ? rt : (j2 == 1) ? {{16{inst[15]}}, inst[15:0]} :
           (j2 == 2) ? 32'd8 : {16'b0, inst[15:0]};
      res = ref_alu(k, a1, a2);
      issue(mk(4'd0, 6'd0, pc, inst, (k == 12) ? 12'h0 : 12'(12'h800 >> k), 3'(1 << j1),
               4'(1 << j2), 1'b0, 4'h0, 1'b1, wa, 1'b1, rs, rt));
      check("alu_ex_to_id", 80'(bus_if.ex_to_id), 80'({1'b1, wa, res}));
      check("alu_ex_to_mem", bus_if.ex_to_mem_bus,
            {4'd0, pc, 1'b0, 4'h0, 1'b1, 1'b1, wa, res});
    end

    // sb rt=0x12345678 at 0x1003
    issue(mk(4'b0101, 6'd0, 32'h80, 32'h0000_0003, 12'h800, 3'b001, 4'b0010, 1'b1, 4'hF,
             1'b0, 5'd0, 1'b0, 32'h1000, 32'h1234_5678));
    check("sb_wen", 80'(bus_if.data_sram_wen), 80'(4'b1000));
    check("sb_wdata", 80'(bus_if.data_sram_wdata), 80'(32'h7878_7878));
    check("sb_is_load", 80'(bus_if.ex_is_load), 80'd0);

    // random stores: 0=sw 1=sb 2=sh
    for (int i = 0; i < 12; i++) begin
      kind = int'($urandom_range(0, 2));
      rs = $urandom; rt = $urandom; inst = {16'h0, 16'($urandom)};
      addr = rs + {{16{inst[15]}}, inst[15:0]};
      issue(mk((kind == 1) ? 4'b0101 : (kind == 2) ? 4'b0111 : 4'b0000, 6'd0, 32'h0, inst,
               12'h800, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, rs, rt));
      check("st_addr", 80'(bus_if.data_sram_addr), 80'(addr));
      check("st_wen", 80'(bus_if.data_sram_wen),
            (kind == 0) ? 80'hF : (kind == 1) ? 80'(1 << (addr % 4)) :
            ((addr % 4) >= 2) ? 80'hC : 80'h3);
      check("st_wdata", 80'(bus_if.data_sram_wdata),
            (kind == 0) ? 80'(rt) : (kind == 1) ? 80'({4{rt[7:0]}}) : 80'({2{rt[15:0]}}));
    end

    // lw
    issue(mk(4'b1111, 6'd0, 32'h0, 32'h0000_0010, 12'h800, 3'b001, 4'b0010, 1'b1, 4'h0,
             1'b1, 5'd4, 1'b1, 32'h2000, 32'h0));
    check("lw_is_load", 80'(bus_if.ex_is_load), 80'd1);
    check("lw_wen", 80'(bus_if.data_sram_wen), 80'd0);
    check("lw_fwd_we", 80'(bus_if.ex_to_id[37]), 80'd1);

    // multu spec case then random mult/multu, mthi/mtlo
    issue(mk(4'd0, FMultu, 32'h0, 32'h0, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
             32'hFFFF_FFFF, 32'd2));
    check("multu_hilo", 80'(bus_if.hilo_ex_to_id), 80'({2'b11, 32'd1, 32'hFFFF_FFFE}));
    check("multu_nostall", 80'(bus_if.stallreq_for_ex), 80'd0);
    for (int i = 0; i < 10; i++) begin
      kind = int'($urandom_range(0, 3));
      rs = $urandom; rt = $urandom;
      p = (kind == 0) ? 64'(longint'($signed(rs)) * longint'($signed(rt))) : 64'(rs) * 64'(rt);
      issue(mk(4'd0, (kind == 0) ? FMult : (kind == 1) ? FMultu : (kind == 2) ? FMthi : FMtlo,
               32'h0, 32'h0, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, rs, rt));
      check("hilo", 80'(bus_if.hilo_ex_to_id),
            (kind < 2) ? 80'({2'b11, p}) : (kind == 2) ? 80'({2'b10, rs, 32'd0}) :
            80'({2'b01, 32'd0, rs}));
    end

    run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div(1'b0, 32'd9, 32'd0);
    run_div(1'b1, 32'hFFFF_FFFB, 32'd0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) run_div(1'($urandom), $urandom, $urandom);

    // async reset in the middle of a division
    issue(mk(4'd0, FDiv, 32'h0, 32'h0, 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
             32'd1000, 32'd3));
    bus_if.id_to_ex_bus = '0;
    repeat (10) @(posedge clk);
    #2;
    check("div_mid_busy", 80'(bus_if.stallreq_for_ex), 80'd1);
    rst_n = 1'b0;
    #1;
    check("div_rst_stallreq", 80'(bus_if.stallreq_for_ex), 80'd0);
    check("div_rst_hilo", 80'(bus_if.hilo_ex_to_id), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("div_rst_idle", 80'(bus_if.stallreq_for_ex), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
